urv_mul_iter: RTL and testbench

URV_MUL_ITER -- requirements
Module: urv_mul_iter

---
 rtl/urv_mul_iter_if.sv | 25 ++
 rtl/urv_mul_iter.sv | 174 +++++++++++++++++
 tb/tb_urv_mul_iter.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/urv_mul_iter_if.sv
// Request/response bundle for the iterative multiplier.
// master: the requester driving operands and kill; slave: the multiplier itself.
interface urv_mul_iter_if #(
  parameter int g_width = 32
) ();
  logic               start_i;
  logic [2:0]         fun_i;
  logic [g_width-1:0] rs1_i;
  logic [g_width-1:0] rs2_i;
  logic               kill_i;
  logic               ready_o;
  logic               busy_o;
  logic               done_o;
  logic [g_width-1:0] rd_o;

  modport master (
    output start_i, fun_i, rs1_i, rs2_i, kill_i,
    input  ready_o, busy_o, done_o, rd_o
  );

  modport slave (
    input  start_i, fun_i, rs1_i, rs2_i, kill_i,
    output ready_o, busy_o, done_o, rd_o
  );
endinterface

// File: rtl/urv_mul_iter.sv
// Iterative RISC-V multiplier (MUL/MULH/MULHSU/MULHU) built around one
// g_limb x g_limb unsigned multiplier, one limb product per clock.
// Macro URV_MUL_HIGH_EN enables the high-word variants; without it only the
// low word is computed and MULH* return zero with MUL timing.
module urv_mul_iter #(
  parameter int g_width = 32,
  parameter int g_limb  = 16
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  urv_mul_iter_if.slave     bus
);

  localparam int N  = g_width / g_limb;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);
`ifdef URV_MUL_HIGH_EN
  localparam int ACC_W = 2 * g_width;
`else
  localparam int ACC_W = g_width;
`endif

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX} state_t;

  state_t             r_state;
  state_t             w_next;
  logic [g_width-1:0] r_a;
  logic [g_width-1:0] r_b;
  logic [2:0]         r_fun;
  logic [ACC_W-1:0]   r_acc;
  logic [CW-1:0]      r_i;
  logic [CW-1:0]      r_j;
  logic [g_width-1:0] r_rd;
  logic               r_done;

  logic               w_accept;
  logic               w_high;
  logic               w_full_iter;
  logic [CW-1:0]      w_jmax;
  logic               w_last;
  logic [g_limb-1:0]  w_la;
  logic [g_limb-1:0]  w_lb;
  logic [2*g_limb-1:0] w_prod;
  logic [CW:0]        w_sh;
  logic [ACC_W-1:0]   w_term;
  logic [g_width-1:0] w_word;
  logic [g_width-1:0] w_mag1;
  logic [g_width-1:0] w_mag2;

`ifdef URV_MUL_HIGH_EN
  logic               r_sign;
  logic               w_neg1;
  logic               w_neg2;
  logic [ACC_W-1:0]   w_fixed;

  // Two's-complement magnitude; -2^(g_width-1) maps to 2^(g_width-1) unsigned.
  function automatic logic [g_width-1:0] mag_f(input logic signed [g_width-1:0] x,
                                               input logic neg);
    return neg ? g_width'(-x) : g_width'(x);
  endfunction

  // Negate the full-width product when the operand signs differ.
  function automatic logic [ACC_W-1:0] neg_acc_f(input logic [ACC_W-1:0] x,
                                                 input logic neg);
    return neg ? ACC_W'(-x) : x;
  endfunction

  // MULH treats both operands signed, MULHSU only rs1.
  assign w_neg1 = ((bus.fun_i == 3'b001) || (bus.fun_i == 3'b010)) &&
                  ($signed(bus.rs1_i) < 0);
  assign w_neg2 = (bus.fun_i == 3'b001) && ($signed(bus.rs2_i) < 0);
  assign w_mag1 = mag_f($signed(bus.rs1_i), w_neg1);
  assign w_mag2 = mag_f($signed(bus.rs2_i), w_neg2);
  assign w_full_iter = w_high;
  assign w_fixed = neg_acc_f(r_acc, r_sign);
  assign w_word  = w_high ? w_fixed[ACC_W-1:g_width] : w_fixed[g_width-1:0];
`else
  assign w_mag1 = bus.rs1_i;
  assign w_mag2 = bus.rs2_i;
  assign w_full_iter = 1'b0;
  assign w_word  = w_high ? '0 : r_acc;
`endif

  assign w_accept = bus.start_i & (r_state == S_IDLE) & ~bus.kill_i;
  assign w_high   = (r_fun == 3'b001) || (r_fun == 3'b010) || (r_fun == 3'b011);

  // MUL only needs the partial products landing in the low word (i+j < N).
  assign w_jmax = w_full_iter ? LAST : (LAST - r_i);
  assign w_last = (r_i == LAST) && (r_j == w_jmax);

  assign w_la   = g_limb'(r_a >> (r_i * g_limb));
  assign w_lb   = g_limb'(r_b >> (r_j * g_limb));
  assign w_prod = {{g_limb{1'b0}}, w_la} * {{g_limb{1'b0}}, w_lb};
  assign w_sh   = {1'b0, r_i} + {1'b0, r_j};
  assign w_term = ACC_W'((2 * g_width)'(w_prod) << (w_sh * g_limb));

  // State register.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) r_state <= S_IDLE;
    else          r_state <= w_next;
  end

  // Next-state: kill returns to IDLE from any busy state.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_accept) w_next = S_CALC;
      S_CALC:  if (bus.kill_i) w_next = S_IDLE;
               else if (w_last) w_next = S_FIX;
      S_FIX:   w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Operand capture, limb accumulation and result writeback.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_a    <= '0;
      r_b    <= '0;
      r_fun  <= '0;
      r_acc  <= '0;
      r_i    <= '0;
      r_j    <= '0;
      r_rd   <= '0;
      r_done <= 1'b0;
`ifdef URV_MUL_HIGH_EN
      r_sign <= 1'b0;
`endif
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_a   <= w_mag1;
            r_b   <= w_mag2;
            r_fun <= bus.fun_i;
            r_acc <= '0;
            r_i   <= '0;
            r_j   <= '0;
`ifdef URV_MUL_HIGH_EN
            r_sign <= w_neg1 ^ w_neg2;
`endif
          end
        end
        S_CALC: begin
          if (bus.kill_i) begin
            r_acc <= '0;
          end else begin
            r_acc <= r_acc + w_term;
            if (r_j == w_jmax) begin
              r_j <= '0;
              r_i <= r_i + CW'(1);
            end else begin
              r_j <= r_j + CW'(1);
            end
          end
        end
        S_FIX: begin
          if (!bus.kill_i) begin
            r_rd   <= w_word;
            r_done <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.ready_o = (r_state == S_IDLE);
  assign bus.busy_o  = (r_state == S_CALC) || (r_state == S_FIX);
  assign bus.done_o  = r_done;
  assign bus.rd_o    = r_rd;

endmodule

// File: tb/tb_urv_mul_iter.sv
// Scoreboard bench for urv_mul_iter: stimulus pushes expected results with
// their due cycle; a monitor pops and compares on every done_o.
module tb_urv_mul_iter;

`ifdef URV_MUL_HIGH_EN
  localparam bit HI = 1'b1;
`else
  localparam bit HI = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  urv_mul_iter_if #(.g_width(32)) u_if ();
  urv_mul_iter #(.g_width(32), .g_limb(16)) dut (
    .clk_i   (clk),
    .rst_n_i (rst_n),
    .bus     (u_if)
  );

  typedef struct {
    logic [31:0] rd;
    int          cyc;
    string       name;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  int   last_exp_done = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  function automatic bit is_high(input logic [2:0] f);
    return (f == 3'b001) || (f == 3'b010) || (f == 3'b011);
  endfunction

  // Wait for ready, present one request, push its expected result.
  task automatic issue(input string nm, input logic [2:0] f, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] e, input bit b2b);
    int n = 0;
    @(negedge clk);
    while (!u_if.ready_o && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) begin
      total++;
      bad++;
      $display("FAIL %s ready_timeout: got busy want ready", nm);
      return;
    end
    if (b2b) chk({nm, " b2b_accept_cycle"}, cyc, last_exp_done);
    u_if.start_i = 1'b1;
    u_if.fun_i   = f;
    u_if.rs1_i   = a;
    u_if.rs2_i   = b;
    last_exp_done = cyc + ((is_high(f) && HI) ? 6 : 5);
    q.push_back('{rd: (is_high(f) && !HI) ? 32'h0 : e, cyc: last_exp_done, name: nm});
    @(negedge clk);
    u_if.start_i = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while ((q.size() != 0 || !u_if.ready_o) && n < 40) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (q.size() != 0) begin
      bad++;
      $display("FAIL drain: got %0d pending want 0", q.size());
    end
  endtask

  // Monitor: every done_o must match the oldest outstanding expectation.
  always @(negedge clk) begin : mon
    exp_t e;
    if (rst_n && u_if.done_o) begin
      if (q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_done: got rd %h want no done", u_if.rd_o);
      end else begin
        e = q.pop_front();
        chk({e.name, " rd"}, u_if.rd_o, e.rd);
        chk({e.name, " done_cycle"}, cyc, e.cyc);
        chk({e.name, " ready_with_done"}, {31'b0, u_if.ready_o}, 32'd1);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int c;
    u_if.start_i = 1'b0;
    u_if.fun_i   = 3'b000;
    u_if.rs1_i   = '0;
    u_if.rs2_i   = '0;
    u_if.kill_i  = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("reset ready", {31'b0, u_if.ready_o}, 32'd1);
    chk("reset busy",  {31'b0, u_if.busy_o},  32'd0);
    chk("reset done",  {31'b0, u_if.done_o},  32'd0);
    chk("reset rd",    u_if.rd_o,             32'd0);
    rst_n = 1'b1;

    issue("MUL ff*ff",        3'b000, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 1'b0);
    issue("MULH 8m*8m",       3'b001, 32'h80000000, 32'h80000000, 32'h40000000, 1'b1);
    issue("MULHU ff*ff",      3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 1'b1);
    issue("MULHSU ff*ff",     3'b010, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1);
    issue("MULH -2*3",        3'b001, 32'hFFFFFFFE, 32'h00000003, 32'hFFFFFFFF, 1'b1);
    issue("MULH 7f*7f",       3'b001, 32'h7FFFFFFF, 32'h7FFFFFFF, 32'h3FFFFFFF, 1'b1);
    issue("MULHSU 8m*8m",     3'b010, 32'h80000000, 32'h80000000, 32'hC0000000, 1'b1);
    issue("MULHU 8m*2",       3'b011, 32'h80000000, 32'h00000002, 32'h00000001, 1'b1);
    issue("MULH -1*-1",       3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 1'b1);
    issue("MUL 8m*8m",        3'b000, 32'h80000000, 32'h80000000, 32'h00000000, 1'b1);
    issue("MUL 10001sq",      3'b000, 32'h00010001, 32'h00010001, 32'h00020001, 1'b1);
    issue("fun7 5*5",         3'b111, 32'd5,        32'd5,        32'd25,       1'b1);
    drain();

    // Kill in CALC: no done, back to IDLE next cycle, rd keeps 25.
    @(negedge clk);
    u_if.start_i = 1'b1;
    u_if.fun_i   = 3'b001;
    u_if.rs1_i   = 32'h12345678;
    u_if.rs2_i   = 32'h9ABCDEF0;
    @(negedge clk);
    u_if.start_i = 1'b0;
    @(negedge clk);
    u_if.kill_i = 1'b1;
    @(negedge clk);
    u_if.kill_i = 1'b0;
    chk("kill ready", {31'b0, u_if.ready_o}, 32'd1);
    chk("kill busy",  {31'b0, u_if.busy_o},  32'd0);
    chk("kill rd_hold", u_if.rd_o, 32'd25);
    issue("MUL 7*6", 3'b000, 32'd7, 32'd6, 32'h0000002A, 1'b0);

    // start while busy must be ignored.
    issue("MUL 3*3", 3'b000, 32'd3, 32'd3, 32'd9, 1'b0);
    u_if.start_i = 1'b1;
    u_if.rs1_i   = 32'd100;
    u_if.rs2_i   = 32'd100;
    @(negedge clk);
    @(negedge clk);
    u_if.start_i = 1'b0;
    drain();

    // kill and start together in IDLE: nothing accepted.
    @(negedge clk);
    u_if.start_i = 1'b1;
    u_if.kill_i  = 1'b1;
    u_if.rs1_i   = 32'd2;
    u_if.rs2_i   = 32'd2;
    @(negedge clk);
    u_if.start_i = 1'b0;
    u_if.kill_i  = 1'b0;
    chk("kill+start ready", {31'b0, u_if.ready_o}, 32'd1);
    chk("kill+start busy",  {31'b0, u_if.busy_o},  32'd0);
    for (int k = 0; k < 6; k++) @(negedge clk);

    // Asynchronous reset during CALC.
    u_if.start_i = 1'b1;
    u_if.fun_i   = 3'b000;
    u_if.rs1_i   = 32'd3;
    u_if.rs2_i   = 32'd5;
    @(negedge clk);
    u_if.start_i = 1'b0;
    @(negedge clk);
    c = cyc;
    #1 rst_n = 1'b0;
    #1;
    chk("arst ready", {31'b0, u_if.ready_o}, 32'd1);
    chk("arst busy",  {31'b0, u_if.busy_o},  32'd0);
    chk("arst done",  {31'b0, u_if.done_o},  32'd0);
    chk("arst rd",    u_if.rd_o,             32'd0);
    chk("arst before_edge", cyc, c);
    @(negedge clk);
    rst_n = 1'b1;
    issue("MUL ffff sq", 3'b000, 32'h0000FFFF, 32'h0000FFFF, 32'hFFFE0001, 1'b0);
    issue("MUL x*1",     3'b000, 32'h12345678, 32'h00000001, 32'h12345678, 1'b1);
    issue("MUL 7*6 b2b", 3'b000, 32'd7,        32'd6,        32'h0000002A, 1'b1);
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
